// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, counter sizing
// and parameter legality.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StWaitRdy = 2'd2,
        StGap     = 2'd3
    } seq_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One spare bit so the phase counter can never wrap before its compare hits.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned stage_gap,
                                              input int unsigned ready_timeout);
        return $clog2(max3(hold_cycles, stage_gap, ready_timeout)) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

    function automatic bit params_legal(input int unsigned num_stages,
                                        input int unsigned hold_cycles,
                                        input int unsigned stage_gap,
                                        input int unsigned ready_timeout);
        return (num_stages >= 1) && (num_stages <= 8) && (hold_cycles >= 1) &&
               (stage_gap >= 1) && (ready_timeout >= 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/acknowledge and status bundle between the reset sequencer and the
// domains it controls.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
);

    logic                  rst_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  seq_busy;
    logic                  seq_done;
    logic [NUM_STAGES-1:0] timeout_flags;

    modport master (
        input  rst_req,
        input  stage_ready,
        output stage_rst,
        output seq_busy,
        output seq_done,
        output timeout_flags
    );

    modport slave (
        output rst_req,
        output stage_ready,
        input  stage_rst,
        input  seq_busy,
        input  seq_done,
        input  timeout_flags
    );

endinterface

// File: rtl/seq_timer.sv
// Phase counter shared by the hold, ready-wait and gap phases; flags the edge on
// which the selected phase length is reached.
module seq_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] last_val,
    output logic             expired
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // last_val is the phase length minus one, so this is high on the N-th edge.
    assign expired = (cnt_q == last_val);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all downstream domains in reset, then releases them one by one in index
// order, each after its ready acknowledge (or a timeout) and a fixed gap.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned STAGE_GAP     = 8,
    parameter int unsigned READY_TIMEOUT = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    reset_sequencer_if.master   bus
);

    localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGE_GAP, READY_TIMEOUT);
    localparam int unsigned IW = idx_width(NUM_STAGES);

    localparam logic [IW-1:0] LastIdx     = IW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] HoldLast    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GapLast     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(READY_TIMEOUT - 1);

    if (!params_legal(NUM_STAGES, HOLD_CYCLES, STAGE_GAP, READY_TIMEOUT)) begin : g_param_check
        $error("reset_sequencer: illegal parameter combination");
    end

    seq_state_e            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic [NUM_STAGES-1:0] flags_q, flags_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  timer_clr;
    logic                  timer_en;
    logic [CW-1:0]         timer_last;
    logic                  timer_expired;
    logic                  ready_sel;

    seq_timer #(
        .Width (CW)
    ) u_seq_timer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clr      (timer_clr),
        .en       (timer_en),
        .last_val (timer_last),
        .expired  (timer_expired)
    );

    always_comb begin
        timer_last = '0;
        unique case (state_q)
            StAssert:  timer_last = HoldLast;
            StWaitRdy: timer_last = TimeoutLast;
            StGap:     timer_last = GapLast;
            default:   timer_last = '0;
        endcase
    end

    assign ready_sel = bus.stage_ready[idx_q];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        flags_d     = flags_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = (state_q != StIdle);

        // A new request restarts from any state, even on the would-be done edge.
        if (bus.rst_req) begin
            state_d     = StAssert;
            idx_d       = '0;
            stage_rst_d = '1;
            flags_d     = '0;
            busy_d      = 1'b1;
            timer_clr   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_d = 1'b0;
                end
                StAssert: begin
                    if (timer_expired) begin
                        stage_rst_d[0] = 1'b0;
                        timer_clr      = 1'b1;
                        state_d        = StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (ready_sel || timer_expired) begin
                        if (!ready_sel) begin
                            flags_d[idx_q] = 1'b1;
                        end
                        timer_clr = 1'b1;
                        if (idx_q == LastIdx) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    if (timer_expired) begin
                        idx_d              = idx_q + IW'(1);
                        stage_rst_d[idx_d] = 1'b0;
                        timer_clr          = 1'b1;
                        state_d            = StWaitRdy;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StAssert;
            idx_q       <= '0;
            stage_rst_q <= '1;
            flags_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.stage_rst     = stage_rst_q;
    assign bus.seq_busy      = busy_q;
    assign bus.seq_done      = done_q;
    assign bus.timeout_flags = flags_q;

endmodule
